weight_pair_fetch: RTL

//  Downstream consumer of the dual-port weight address generator. Gates the generator's

---
 rtl/weight_pair_fetch_pkg.sv | 31 +++
 rtl/weight_pair_fifo.sv | 69 ++++++
 rtl/weight_pair_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/weight_pair_fetch_pkg.sv
// Shared constants and types for the weight pair fetch path: memory latency, pair buffer
// sizing, default layer geometry and the packed weight pair.
package weight_pair_fetch_pkg;

    localparam int WEIGHT_WIDTH = 16;
    localparam int MEM_LATENCY  = 2;
    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_AW      = 3;

    // Default layer geometry; instances override these through top-level parameters.
    localparam int DEF_NUM_ONE_PIXEL_CYCLE = 4;
    localparam int DEF_OUT_FEATURE_WIDTH_W = 2;
    localparam int DEF_OUT_FEATURE_WIDTH_H = 2;
    localparam int DEF_NUM_ONEMULT         = 1;

    typedef struct packed {
        logic [WEIGHT_WIDTH-1:0] w0;
        logic [WEIGHT_WIDTH-1:0] w1;
    } weight_pair_t;

    // Reads in flight = ones in the issue shift register, sized for the credit compare.
    function automatic logic [FIFO_AW+1:0] count_ones(input logic [MEM_LATENCY-1:0] v);
        logic [FIFO_AW+1:0] n;
        n = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            n = n + {{(FIFO_AW+1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/weight_pair_fifo.sv
// Synchronous first-word-fall-through FIFO holding weight pairs; the head entry is visible
// on dout_o whenever the FIFO is not empty and reads as zero otherwise.
module weight_pair_fifo
    import weight_pair_fetch_pkg::*;
#(
    parameter int WIDTH = 2 * WEIGHT_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [AW:0]      count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/weight_pair_fetch.sv
// Credit-gated issue of weight address pairs, alignment of the returning memory data,
// and tagged valid/ready delivery of the buffered pairs to the MAC array.
module weight_pair_fetch
    import weight_pair_fetch_pkg::*;
#(
    parameter int NUM_ONE_PIXEL_CYCLE = DEF_NUM_ONE_PIXEL_CYCLE,
    parameter int OUT_FEATURE_WIDTH_W = DEF_OUT_FEATURE_WIDTH_W,
    parameter int OUT_FEATURE_WIDTH_H = DEF_OUT_FEATURE_WIDTH_H,
    parameter int NUM_ONEMULT         = DEF_NUM_ONEMULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    gen_enable,
    input  logic [WEIGHT_WIDTH-1:0] douta,
    input  logic [WEIGHT_WIDTH-1:0] doutb,
    input  logic                    w_ready,
    output logic                    w_valid,
    output logic [WEIGHT_WIDTH-1:0] w0,
    output logic [WEIGHT_WIDTH-1:0] w1,
    output logic                    w_first,
    output logic                    w_last,
    output logic                    layer_done
);

    localparam int PIXELS = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H;
    localparam int TOTAL  = NUM_ONE_PIXEL_CYCLE * PIXELS * NUM_ONEMULT;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int BEAT_W = (NUM_ONE_PIXEL_CYCLE > 1) ? $clog2(NUM_ONE_PIXEL_CYCLE) : 1;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int MAP_W  = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1;

    logic [MEM_LATENCY-1:0]  issue_sr_q, issue_sr_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic                    issue_done_q, issue_done_d;
    logic [CNT_W-1:0]        pop_cnt_q, pop_cnt_d;
    logic                    layer_done_q, layer_done_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic [MAP_W-1:0]        map_cnt_q, map_cnt_d;

    logic [FIFO_AW:0]        fifo_count;
    logic                    fifo_empty, fifo_full;
    logic [FIFO_AW+1:0]      inflight, occupancy;
    logic                    push, pop;
    weight_pair_t            push_pair, head_pair;
    logic [2*WEIGHT_WIDTH-1:0] head_bits;

    // A read issued MEM_LATENCY cycles ago has its data on douta/doutb right now.
    assign push      = issue_sr_q[MEM_LATENCY-1];
    assign push_pair = '{w0: douta, w1: doutb};

    weight_pair_fifo #(
        .WIDTH (2 * WEIGHT_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_pair),
        .pop_i   (pop),
        .dout_o  (head_bits),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Credit: buffered plus in-flight pairs must leave room for the one being issued.
    assign inflight   = count_ones(issue_sr_q);
    assign occupancy  = {1'b0, fifo_count} + inflight;
    assign gen_enable = ~reset & enable & ~issue_done_q &
                        (occupancy < (FIFO_AW+2)'(FIFO_DEPTH));

    assign head_pair  = head_bits;
    assign w_valid    = ~fifo_empty & ~layer_done_q;
    assign pop        = w_valid & w_ready;
    assign w0         = head_pair.w0;
    assign w1         = head_pair.w1;
    assign w_first    = w_valid & (beat_cnt_q == '0);
    assign w_last     = w_valid & (beat_cnt_q == BEAT_W'(NUM_ONE_PIXEL_CYCLE - 1));
    assign layer_done = layer_done_q;

    always_comb begin
        issue_sr_d   = (issue_sr_q << 1) | MEM_LATENCY'(gen_enable);
        issue_cnt_d  = issue_cnt_q;
        issue_done_d = issue_done_q;
        pop_cnt_d    = pop_cnt_q;
        layer_done_d = layer_done_q;
        beat_cnt_d   = beat_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        map_cnt_d    = map_cnt_q;
        if (gen_enable) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (issue_cnt_q == CNT_W'(TOTAL - 1)) begin
                issue_done_d = 1'b1;
            end
        end
        // Tag counters nest beat -> pixel -> map and only move on an accepted pair.
        if (pop) begin
            pop_cnt_d = pop_cnt_q + CNT_W'(1);
            if (pop_cnt_q == CNT_W'(TOTAL - 1)) begin
                layer_done_d = 1'b1;
            end
            if (beat_cnt_q == BEAT_W'(NUM_ONE_PIXEL_CYCLE - 1)) begin
                beat_cnt_d = '0;
                if (pix_cnt_q == PIX_W'(PIXELS - 1)) begin
                    pix_cnt_d = '0;
                    map_cnt_d = (map_cnt_q == MAP_W'(NUM_ONEMULT - 1)) ? '0 : map_cnt_q + MAP_W'(1);
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                end
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_sr_q   <= '0;
            issue_cnt_q  <= '0;
            issue_done_q <= 1'b0;
            pop_cnt_q    <= '0;
            layer_done_q <= 1'b0;
            beat_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            map_cnt_q    <= '0;
        end else begin
            issue_sr_q   <= issue_sr_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_done_q <= issue_done_d;
            pop_cnt_q    <= pop_cnt_d;
            layer_done_q <= layer_done_d;
            beat_cnt_q   <= beat_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            map_cnt_q    <= map_cnt_d;
        end
    end

    // The credit rule should make this impossible; a firing means the accounting is broken.
    always_ff @(posedge clk) begin
        assert (!(push && fifo_full && !pop))
            else $error("weight_pair_fetch: pair buffer overflow");
    end

endmodule
